// File: rtl/channel_sel_pkg.sv
// Shared state encoding, reset constants and width helpers for channel_sel_mux.
package channel_sel_pkg;

  typedef enum logic {
    LOCKED   = 1'b0,
    BLANKING = 1'b1
  } mux_state_t;

  localparam mux_state_t RST_STATE   = LOCKED;
  localparam logic       RST_SEL_ERR = 1'b0;

  // Width of a channel index; never below one bit.
  function automatic int sel_width(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

  // Width of a counter that must hold values 0..maxval.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter shared by the blanking and dwell timing; stops at zero.
module blank_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/channel_sel_mux.sv
// N-channel display selector with blanked channel switching.
// Optional auto-scan rotation is built only when MUX_SCAN_EN is defined.
module channel_sel_mux
  import channel_sel_pkg::*;
#(
  parameter int                WIDTH     = 3,
  parameter int                NCH       = 4,
  localparam int               SELW      = sel_width(NCH),
  parameter int                BLANK     = 2,
`ifdef MUX_SCAN_EN
  parameter int                DWELL     = 8,
`endif
  parameter logic [WIDTH-1:0]  BLANK_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_load,
`ifdef MUX_SCAN_EN
  input  logic                 scan,
`endif
  output logic [WIDTH-1:0]     result,
  output logic [SELW-1:0]      active_ch,
  output logic                 switching,
  output logic                 sel_err
);

  localparam int BW = cnt_width(BLANK);

  mux_state_t       state, state_nxt;
  logic [SELW-1:0]  target, target_nxt, active_nxt, req_ch;
  logic [WIDTH-1:0] result_nxt;
  logic [WIDTH-1:0] chans [NCH];
  logic [BW-1:0]    blank_cnt;
  logic             sel_in_range, sel_ok, req, blank_load, blank_last;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign chans[k] = ch_data[k*WIDTH +: WIDTH];
  end

  assign sel_in_range = (int'(sel) < NCH);
  assign sel_ok       = sel_load && sel_in_range;
  assign blank_last   = (blank_cnt == BW'(1));
  assign switching    = (state == BLANKING);

  blank_timer #(.CW(BW)) u_blank (
    .clk      (clk),
    .rst      (rst),
    .load     (blank_load),
    .load_val (BW'(BLANK)),
    .dec      (state == BLANKING),
    .count    (blank_cnt)
  );

`ifdef MUX_SCAN_EN
  localparam int DW = cnt_width(DWELL);

  logic [DW-1:0]   dwell_cnt, dwell_val;
  logic [SELW-1:0] next_ch;
  logic            scan_run, dwell_last, dwell_hold;

  // A zero count marks the first scanning cycle, which preloads DWELL-1.
  assign scan_run   = (state == LOCKED) && scan;
  assign dwell_last = scan_run &&
                      ((dwell_cnt == '0) ? (DWELL <= 1) : (dwell_cnt == DW'(1)));
  assign dwell_hold = !scan_run || sel_ok || dwell_last;
  assign dwell_val  = dwell_hold ? '0 : DW'(DWELL - 1);
  assign next_ch    = (active_ch == SELW'(NCH - 1)) ? '0 : active_ch + SELW'(1);

  blank_timer #(.CW(DW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_hold || (dwell_cnt == '0)),
    .load_val (dwell_val),
    .dec      (1'b1),
    .count    (dwell_cnt)
  );
`endif

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block infers a latch.
    state_nxt  = state;
    target_nxt = target;
    active_nxt = active_ch;
    blank_load = 1'b0;
    req        = 1'b0;
    req_ch     = sel;

    // An explicit load always beats a scan advance in the same cycle.
    if (sel_ok) begin
      req = (sel != active_ch);
    end
`ifdef MUX_SCAN_EN
    else if (dwell_last) begin
      req    = 1'b1;
      req_ch = next_ch;
    end
`endif

    case (state)
      LOCKED: begin
        if (req) begin
          if (BLANK == 0) begin
            active_nxt = req_ch;
          end else begin
            state_nxt  = BLANKING;
            target_nxt = req_ch;
            blank_load = 1'b1;
          end
        end
      end
      BLANKING: begin
        if (sel_ok) begin
          target_nxt = sel;
          blank_load = 1'b1;
        end else if (blank_last) begin
          state_nxt  = LOCKED;
          active_nxt = target;
        end
      end
      default: state_nxt = LOCKED;
    endcase

    // Blank whenever this or the next cycle is not a settled LOCKED cycle.
    result_nxt = ((state == LOCKED) && (state_nxt == LOCKED)) ? chans[active_ch] : BLANK_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      target    <= '0;
      active_ch <= '0;
      result    <= '0;
      sel_err   <= RST_SEL_ERR;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      active_ch <= active_nxt;
      result    <= result_nxt;
      sel_err   <= sel_load && !sel_in_range;
    end
  end

endmodule

// File: tb/tb_channel_sel_mux.sv
// Directed bench for channel_sel_mux: a 4-channel blanking instance and a 3-channel BLANK=0 instance.
module tb_channel_sel_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = '0;
  logic        sel_load = 1'b0;
`ifdef MUX_SCAN_EN
  logic        scan = 1'b0;
`endif
  // ch0=5 ch1=6 ch2=3 ch3=7 on the 4-channel instance; ch0=1 ch1=2 ch2=4 on the 3-channel one.
  logic [11:0] data4 = {3'd7, 3'd3, 3'd6, 3'd5};
  logic [8:0]  data3 = {3'd4, 3'd2, 3'd1};

  logic [2:0]  result, result3;
  logic [1:0]  active_ch, active3;
  logic        switching, switching3, sel_err, sel_err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  channel_sel_mux #(.WIDTH(3), .NCH(4), .BLANK(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ch_data   (data4),
    .sel       (sel),
    .sel_load  (sel_load),
`ifdef MUX_SCAN_EN
    .scan      (scan),
`endif
    .result    (result),
    .active_ch (active_ch),
    .switching (switching),
    .sel_err   (sel_err)
  );

  channel_sel_mux #(.WIDTH(3), .NCH(3), .BLANK(0)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .ch_data   (data3),
    .sel       (sel),
    .sel_load  (sel_load),
`ifdef MUX_SCAN_EN
    .scan      (scan),
`endif
    .result    (result3),
    .active_ch (active3),
    .switching (switching3),
    .sel_err   (sel_err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    sel_load = 1'b0;
`ifdef MUX_SCAN_EN
    scan     = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (result !== 3'd0) begin
      errors++; $display("FAIL reset_result: got %0d expected 0", result);
    end
    checks++;
    if (active_ch !== 2'd0) begin
      errors++; $display("FAIL reset_active_ch: got %0d expected 0", active_ch);
    end
    checks++;
    if (switching !== 1'b0 || sel_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: switching=%0b sel_err=%0b expected 0 0", switching, sel_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (result !== 3'd5) begin
      errors++; $display("FAIL reset_release_result: got %0d expected 5", result);
    end
    checks++;
    if (result3 !== 3'd1) begin
      errors++; $display("FAIL reset_release_result3: got %0d expected 1", result3);
    end
  endtask

  task automatic test_switch();
    logic [2:0] exp_res [4];
    logic [1:0] exp_act [4];
    logic       exp_sw  [4];
    exp_res = '{3'd0, 3'd0, 3'd0, 3'd3};
    exp_act = '{2'd0, 2'd0, 2'd2, 2'd2};
    exp_sw  = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    sel = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result !== exp_res[i] || active_ch !== exp_act[i] || switching !== exp_sw[i]) begin
        errors++;
        $display("FAIL switch cycle %0d: result=%0d active_ch=%0d switching=%0b expected %0d %0d %0b",
                 i + 1, result, active_ch, switching, exp_res[i], exp_act[i], exp_sw[i]);
      end
      tick();
    end
  endtask

  task automatic test_retarget();
    logic [2:0] exp_res [4];
    logic [1:0] exp_act [4];
    logic       exp_sw  [4];
    exp_sw = '{1'b1, 1'b1, 1'b0, 1'b0};
    // Latest valid load during blanking wins and restarts the blank count.
    do_reset();
    sel = 2'd2; sel_load = 1'b1;
    tick();
    checks++;
    if (switching !== 1'b1) begin
      errors++; $display("FAIL retarget_first_blank: switching=%0b expected 1", switching);
    end
    sel = 2'd1;
    tick();
    sel_load = 1'b0;
    exp_res = '{3'd0, 3'd0, 3'd0, 3'd6};
    exp_act = '{2'd0, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result !== exp_res[i] || active_ch !== exp_act[i] || switching !== exp_sw[i]) begin
        errors++;
        $display("FAIL retarget cycle %0d: result=%0d active_ch=%0d switching=%0b expected %0d %0d %0b",
                 i + 2, result, active_ch, switching, exp_res[i], exp_act[i], exp_sw[i]);
      end
      tick();
    end
    // Retarget back to the current channel still completes a full blank.
    do_reset();
    sel = 2'd1; sel_load = 1'b1;
    tick();
    sel = 2'd0;
    tick();
    sel_load = 1'b0;
    exp_res = '{3'd0, 3'd0, 3'd0, 3'd5};
    exp_act = '{2'd0, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result !== exp_res[i] || active_ch !== exp_act[i] || switching !== exp_sw[i]) begin
        errors++;
        $display("FAIL same_ch_retarget cycle %0d: result=%0d active_ch=%0d switching=%0b expected %0d %0d %0b",
                 i + 2, result, active_ch, switching, exp_res[i], exp_act[i], exp_sw[i]);
      end
      tick();
    end
  endtask

  task automatic test_sel_err();
    do_reset();
    sel = 2'd0; sel_load = 1'b1;
    tick();
    sel = 2'd3;
    checks++;
    if (switching !== 1'b0 || sel_err !== 1'b0 || result !== 3'd5 || active_ch !== 2'd0) begin
      errors++;
      $display("FAIL noop_load: switching=%0b sel_err=%0b result=%0d active_ch=%0d expected 0 0 5 0",
               switching, sel_err, result, active_ch);
    end
    tick();
    sel_load = 1'b0;
    checks++;
    if (sel_err3 !== 1'b1) begin
      errors++; $display("FAIL sel_err_pulse: got %0b expected 1", sel_err3);
    end
    checks++;
    if (active3 !== 2'd0 || result3 !== 3'd1 || switching3 !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_hold: active_ch=%0d result=%0d switching=%0b expected 0 1 0",
               active3, result3, switching3);
    end
    tick();
    checks++;
    if (sel_err3 !== 1'b0 || active3 !== 2'd0 || result3 !== 3'd1) begin
      errors++;
      $display("FAIL sel_err_end: sel_err=%0b active_ch=%0d result=%0d expected 0 0 1",
               sel_err3, active3, result3);
    end
  endtask

  task automatic test_blank0();
    do_reset();
    sel = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    checks++;
    if (active3 !== 2'd2 || switching3 !== 1'b0 || result3 !== 3'd1) begin
      errors++;
      $display("FAIL blank0_switch: active_ch=%0d switching=%0b result=%0d expected 2 0 1",
               active3, switching3, result3);
    end
    tick();
    checks++;
    if (result3 !== 3'd4 || switching3 !== 1'b0) begin
      errors++;
      $display("FAIL blank0_result: result=%0d switching=%0b expected 4 0", result3, switching3);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    sel = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    checks++;
    if (switching !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: switching=%0b expected 1", switching);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (result !== 3'd0 || active_ch !== 2'd0 || switching !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: result=%0d active_ch=%0d switching=%0b sel_err=%0b expected 0 0 0 0",
               result, active_ch, switching, sel_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (result !== 3'd5 || active_ch !== 2'd0 || switching !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_discard: result=%0d active_ch=%0d switching=%0b expected 5 0 0",
               result, active_ch, switching);
    end
  endtask

`ifdef MUX_SCAN_EN
  task automatic test_scan();
    do_reset();
    sel = 2'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    tick();
    scan = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (active_ch !== 2'd3 || switching !== 1'b0) begin
      errors++;
      $display("FAIL scan_dwell: active_ch=%0d switching=%0b expected 3 0", active_ch, switching);
    end
    tick();
    checks++;
    if (switching !== 1'b1 || active_ch !== 2'd3) begin
      errors++;
      $display("FAIL scan_blank: switching=%0b active_ch=%0d expected 1 3", switching, active_ch);
    end
    tick();
    tick();
    checks++;
    if (active_ch !== 2'd0 || switching !== 1'b0) begin
      errors++;
      $display("FAIL scan_wrap: active_ch=%0d switching=%0b expected 0 0", active_ch, switching);
    end
    for (int i = 0; i < 7; i++) tick();
    sel = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    tick();
    checks++;
    if (active_ch !== 2'd2) begin
      errors++; $display("FAIL scan_load_priority: active_ch=%0d expected 2", active_ch);
    end
    tick();
    checks++;
    if (result !== 3'd3) begin
      errors++; $display("FAIL scan_load_result: result=%0d expected 3", result);
    end
    scan = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_switch();
    test_retarget();
    test_sel_err();
    test_blank0();
    test_rst_mid();
`ifdef MUX_SCAN_EN
    test_scan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
